// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: result sources, load sizes
// and the buffered entry format.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2,
    WB_SRC_RSVD = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2
  } ld_size_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The FIFO holds the already-formatted result, never raw MEM-stage inputs.
  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] value;
    logic [31:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load lane select: picks the byte/halfword addressed by the
// offset and zero- or sign-extends it to 32 bits.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] mem,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  off,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem[7:0];
    case (off)
      2'd0: byte_lane = mem[7:0];
      2'd1: byte_lane = mem[15:8];
      2'd2: byte_lane = mem[23:16];
      2'd3: byte_lane = mem[31:24];
      default: byte_lane = mem[7:0];
    endcase

    // Halfword loads only look at the upper offset bit.
    half_lane = off[1] ? mem[31:16] : mem[15:0];

    case (ld_size_e'(size))
      LD_BYTE: value = {{24{sign & byte_lane[7]}}, byte_lane};
      LD_HALF: value = {{16{sign & half_lane[15]}}, half_lane};
      default: value = mem;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: skid FIFO between MEM and the register file, with result
// formatting at enqueue and head-entry forwarding to decode.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          DEPTH       = 2,
  parameter logic [31:0] LINK_OFFSET = 32'd8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [4:0]  in_waddr,
  input  logic [1:0]  in_src,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_mem,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_sign,
  input  logic [1:0]  in_ld_off,
  input  logic [31:0] in_pc,
  input  logic        hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        commit_valid,
  output logic [31:0] commit_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t     fifo_q [DEPTH];
  wb_entry_t     new_entry;
  wb_entry_t     head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   load_value;
  logic          not_empty;
  logic          push;
  logic          pop;

  wb_load_align u_load_align (
    .mem   (in_mem),
    .size  (in_ld_size),
    .sign  (in_ld_sign),
    .off   (in_ld_off),
    .value (load_value)
  );

  // Reserved source retires without writing; $0 is never written.
  always_comb begin
    new_entry       = '0;
    new_entry.addr  = in_waddr;
    new_entry.pc    = in_pc;
    new_entry.wen   = in_wen && (in_waddr != REG_ZERO);
    case (wb_src_e'(in_src))
      WB_SRC_ALU:  new_entry.value = in_alu;
      WB_SRC_MEM:  new_entry.value = load_value;
      WB_SRC_LINK: new_entry.value = in_pc + LINK_OFFSET;
      WB_SRC_RSVD: begin
        new_entry.value = in_alu;
        new_entry.wen   = 1'b0;
      end
      default:     new_entry.value = in_alu;
    endcase
  end

  assign not_empty = (count != '0);
  assign in_ready  = (count < FULL);
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && !hold;
  assign head      = fifo_q[rd_ptr];

  // Full FIFO refuses input even on a popping cycle: in_ready sees pre-edge count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= new_entry;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rf_we        = pop && head.wen;
  assign rf_waddr     = pop ? head.addr  : '0;
  assign rf_wdata     = pop ? head.value : '0;
  assign commit_valid = pop;
  assign commit_pc    = pop ? head.pc    : '0;

  // Forwarding ignores hold so decode can keep bypassing during a debug halt.
  assign fwd_valid = not_empty && head.wen;
  assign fwd_addr  = not_empty ? head.addr  : '0;
  assign fwd_data  = not_empty ? head.value : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed test-plan cases followed by random
// traffic, checked against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [1:0]  in_src;
  logic [31:0] in_alu;
  logic [31:0] in_mem;
  logic [1:0]  in_ld_size;
  logic        in_ld_sign;
  logic [1:0]  in_ld_off;
  logic [31:0] in_pc;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        commit_valid;
  logic [31:0] commit_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] value;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        valid;
    logic        wen;
    logic [4:0]  waddr;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  off;
    logic [31:0] pc;
  } stim_t;

  exp_t sb_q[$];

  wb_stage #(.DEPTH(DEPTH), .LINK_OFFSET(32'd8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wen       (in_wen),
    .in_waddr     (in_waddr),
    .in_src       (in_src),
    .in_alu       (in_alu),
    .in_mem       (in_mem),
    .in_ld_size   (in_ld_size),
    .in_ld_sign   (in_ld_sign),
    .in_ld_off    (in_ld_off),
    .in_pc        (in_pc),
    .hold         (hold),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result, computed from the formatting rules with plain arithmetic.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int unsigned lane;
    e.addr = s.waddr;
    e.pc   = s.pc;
    e.wen  = s.wen && (s.waddr != 0) && (s.src != 2'd3);
    lane   = 0;
    case (s.src)
      2'd0: lane = s.alu;
      2'd2: lane = s.pc + 32'd8;
      2'd1: begin
        if (s.size == 2'd0) begin
          lane = (s.mem >> (8 * s.off)) & 32'hFF;
          if (s.sign && lane >= 128) lane = lane + 32'hFFFFFF00;
        end else if (s.size == 2'd1) begin
          lane = (s.mem >> (16 * (s.off / 2))) & 32'hFFFF;
          if (s.sign && lane >= 32768) lane = lane + 32'hFFFF0000;
        end else begin
          lane = s.mem;
        end
      end
      default: lane = 0;
    endcase
    e.value = lane;
    return e;
  endfunction

  function automatic stim_t mk(input logic wen, input logic [4:0] waddr, input logic [1:0] src,
                               input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] size,
                               input logic sign, input logic [1:0] off, input logic [31:0] pc);
    stim_t s;
    s.valid = 1'b1; s.wen = wen; s.waddr = waddr; s.src = src; s.alu = alu;
    s.mem = mem; s.size = size; s.sign = sign; s.off = off; s.pc = pc;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    s.wen   = ($urandom_range(0, 7) != 0);
    s.waddr = 5'($urandom_range(0, 31));
    s.src   = 2'($urandom_range(0, 3));
    s.alu   = $urandom;
    s.mem   = $urandom;
    s.size  = 2'($urandom_range(0, 2));
    s.sign  = 1'($urandom_range(0, 1));
    s.off   = 2'($urandom_range(0, 3));
    s.pc    = $urandom;
    return s;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the next cycle.
  task automatic apply_stimulus(input stim_t s, input logic h);
    logic accepted;
    in_valid   = s.valid;
    in_wen     = s.wen;
    in_waddr   = s.waddr;
    in_src     = s.src;
    in_alu     = s.alu;
    in_mem     = s.mem;
    in_ld_size = s.size;
    in_ld_sign = s.sign;
    in_ld_off  = s.off;
    in_pc      = s.pc;
    hold       = h;
    #2;
    accepted = s.valid && in_ready;
    @(posedge clk);
    if (accepted) sb_q.push_back(model(s));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic h);
    stim_t s;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.valid = 1'b0;
    apply_stimulus(s, h);
  endtask

  // Directed retire with a hand-computed expected value, seen one cycle later.
  task automatic directed(input string name, input stim_t s, input logic exp_we, input logic [31:0] exp_data);
    apply_stimulus(s, 1'b0);
    #4;
    chk({name, "_commit"}, 32'(commit_valid), 32'd1);
    chk({name, "_we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we) chk({name, "_data"}, rf_wdata, exp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output();
    chk("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH));
    if (sb_q.size() == 0) begin
      chk("idle_rf_we", 32'(rf_we), 32'd0);
      chk("idle_commit", 32'(commit_valid), 32'd0);
      chk("idle_fwd_valid", 32'(fwd_valid), 32'd0);
    end else begin
      exp_t h;
      h = sb_q[0];
      chk("fwd_valid", 32'(fwd_valid), 32'(h.wen));
      if (h.wen) begin
        chk("fwd_addr", 32'(fwd_addr), 32'(h.addr));
        chk("fwd_data", fwd_data, h.value);
      end
      if (hold) begin
        chk("hold_rf_we", 32'(rf_we), 32'd0);
        chk("hold_commit", 32'(commit_valid), 32'd0);
      end else begin
        chk("commit_valid", 32'(commit_valid), 32'd1);
        chk("commit_pc", commit_pc, h.pc);
        chk("rf_we", 32'(rf_we), 32'(h.wen));
        if (h.wen) begin
          chk("rf_waddr", 32'(rf_waddr), 32'(h.addr));
          chk("rf_wdata", rf_wdata, h.value);
        end
        void'(sb_q.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_output();
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_waddr = '0; in_src = '0;
    in_alu = '0; in_mem = '0; in_ld_size = '0; in_ld_sign = 1'b0; in_ld_off = '0;
    in_pc = '0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_fwd", {fwd_valid, 26'd0, fwd_addr}, 32'd0);
    chk("reset_fwd_data", fwd_data, 32'd0);
    chk("reset_commit", {commit_valid, 31'd0}, 32'd0);
    chk("reset_commit_pc", commit_pc, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    directed("alu", mk(1, 5'd5, 2'd0, 32'h12345678, 0, 0, 0, 0, 32'h100), 1'b1, 32'h12345678);
    directed("lb_s2", mk(1, 5'd6, 2'd1, 0, 32'h80FF7F01, 2'd0, 1, 2'd2, 32'h104), 1'b1, 32'hFFFFFFFF);
    directed("lbu_3", mk(1, 5'd7, 2'd1, 0, 32'h80FF7F01, 2'd0, 0, 2'd3, 32'h108), 1'b1, 32'h00000080);
    directed("lh_s2", mk(1, 5'd8, 2'd1, 0, 32'h80FF7F01, 2'd1, 1, 2'd2, 32'h10C), 1'b1, 32'hFFFF80FF);
    directed("lhu_0", mk(1, 5'd9, 2'd1, 0, 32'h80FF7F01, 2'd1, 0, 2'd0, 32'h110), 1'b1, 32'h00007F01);
    directed("r0", mk(1, 5'd0, 2'd0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h114), 1'b0, 32'd0);
    directed("link", mk(1, 5'd31, 2'd2, 0, 0, 0, 0, 0, 32'hFFFFFFFC), 1'b1, 32'h00000004);

    // hold: third back-to-back input is refused, head is forwarded
    apply_stimulus(mk(1, 5'd10, 2'd0, 32'hAAAA0001, 0, 0, 0, 0, 32'h200), 1'b1);
    apply_stimulus(mk(1, 5'd11, 2'd0, 32'hAAAA0002, 0, 0, 0, 0, 32'h204), 1'b1);
    chk("hold_full_ready", 32'(in_ready), 32'd0);
    chk("hold_fwd_addr", 32'(fwd_addr), 32'd10);
    chk("hold_fwd_data", fwd_data, 32'hAAAA0001);
    apply_stimulus(mk(1, 5'd12, 2'd0, 32'hAAAA0003, 0, 0, 0, 0, 32'h208), 1'b1);
    repeat (3) idle_cycle(1'b0);

    // continuous traffic with no hold keeps one entry in flight
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(mk(1, 5'(13 + i), 2'd0, 32'hBB00 + i, 0, 0, 0, 0, 32'h300 + 4 * i), 1'b0);
    end
    idle_cycle(1'b0);

    // asynchronous reset with two entries buffered
    apply_stimulus(mk(1, 5'd20, 2'd0, 32'hCC000001, 0, 0, 0, 0, 32'h400), 1'b1);
    apply_stimulus(mk(1, 5'd21, 2'd0, 32'hCC000002, 0, 0, 0, 0, 32'h404), 1'b1);
    hold = 1'b0;
    #1;
    chk("prerst_rf_we", 32'(rf_we), 32'd1);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_commit", 32'(commit_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fwd_valid", 32'(fwd_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) idle_cycle(1'b0);

    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      apply_stimulus(s, ($urandom_range(0, 4) == 0));
    end
    repeat (DEPTH + 3) idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly upstream of the 32x32 register file. It drives the regfile `we` / `waddr` / `wdata` ports.
- Accepts retired instructions from the MEM stage over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Selects and formats the result (ALU, load data with byte/halfword extraction, link address) and suppresses writes to $0.
- Exposes the head entry as a bypass source for decode-stage forwarding.

Parameters:
- DEPTH, 2, skid FIFO entries; legal values 2 or 4 (power of two).
- LINK_OFFSET, 8, constant added to the instruction PC for jal/jalr link values.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_wen  in  1  instruction writes a GPR
- in_waddr  in  5  destination register
- in_src  in  2  result source: 0 ALU, 1 MEM, 2 LINK, 3 reserved
- in_alu  in  32  ALU result
- in_mem  in  32  raw aligned load word
- in_ld_size  in  2  0 byte, 1 half, 2 word
- in_ld_sign  in  1  sign-extend a sub-word load
- in_ld_off  in  2  byte offset within the word
- in_pc  in  32  instruction PC
- hold  in  1  freeze retirement (debug halt)
- rf_we  out  1  to regfile `we`
- rf_waddr  out  5  to regfile `waddr`
- rf_wdata  out  32  to regfile `wdata`
- fwd_valid  out  1  head entry carries a pending GPR write
- fwd_addr  out  5  pending destination
- fwd_data  out  32  pending value
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  32  PC of the retired instruction

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, read/write pointers 0, count 0. All outputs 0 except in_ready=1. Reset mid-operation drops every buffered entry; no regfile write occurs on that edge or after.
- Result formatting at enqueue: the FIFO stores the final 32-bit value, not raw inputs.
  - ALU: value = in_alu.
  - LINK: value = in_pc + LINK_OFFSET, modulo 2^32 (wraps).
  - MEM byte: lane = in_mem[8*off+7 : 8*off]; zero- or sign-extended per in_ld_sign.
  - MEM half: lane = in_mem[16*off[1]+15 : 16*off[1]]; off[0] is ignored.
  - MEM word: value = in_mem; offset ignored.
  - src 3: stored with wen forced to 0 (retires, no write).
- Write enable: an entry's wen = in_wen AND (in_waddr != 0). Writes to $0 never reach the regfile.
- Enqueue: occurs when in_valid & in_ready. in_ready = (count < DEPTH), registered-free, combinational from count only.
- Dequeue/retire: occurs when count > 0 and hold == 0. During that cycle:
  - rf_we = head.wen, rf_waddr = head.addr, rf_wdata = head.value.
  - The regfile captures on the same clock edge that pops the entry.
  - commit_valid = 1 and commit_pc = head.pc.
- rf_we, commit_valid: 0 whenever count == 0 or hold == 1.
- Latency: an instruction accepted at edge N into an empty FIFO is presented on rf_* during cycle N+1 and written at edge N+1. There is no same-cycle pass-through.
- Simultaneous enqueue and dequeue: count is unchanged. Accepted even when count == DEPTH? No: in_ready is based on pre-edge count, so a full FIFO refuses input that cycle even if it pops.
- Forwarding: fwd_valid = (count > 0) & head.wen; fwd_addr / fwd_data come from the head. Non-head entries are not forwarded; decode must stall on hazards with them. fwd_* are valid even while hold == 1.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- hold asserted: no pops, enqueue continues until full, and the FIFO contents are preserved unchanged.

Decomposition:
- Shared package/header holds:
  - WB_SRC_ALU / WB_SRC_MEM / WB_SRC_LINK / WB_SRC_RSVD
  - LD_BYTE / LD_HALF / LD_WORD
  - the REG_ZERO constant
- One natural sub-module: `wb_load_align`, a combinational lane select and extension. The FIFO stays inline.

Test Plan:
- Reset then ALU write: in_valid=1, src=ALU, waddr=5, alu=0x12345678 at edge 1 -> cycle 2 rf_we=1, rf_waddr=5, rf_wdata=0x12345678, commit_valid=1; cycle 3 rf_we=0.
- Load formatting: mem=0x80FF7F01. Byte off=2 signed -> 0xFFFFFFFF. Byte off=3 unsigned -> 0x00000080. Half off=2 signed -> 0xFFFF80FF. Half off=0 unsigned -> 0x00007F01.
- $0 and LINK: waddr=0, wen=1 -> commit_valid=1, rf_we=0. Separately, src=LINK, pc=0xFFFFFFFC, waddr=31 -> rf_wdata=0x00000004.
- Back-pressure:
  - hold=1 with three back-to-back inputs -> two accepted, in_ready=0 on the third; fwd shows the first entry.
  - Release hold -> writes retire in order, one per cycle.
  - Same-cycle push/pop keeps count at 1.
- Reset mid-stream: two entries buffered and rst pulsed low asynchronously between edges -> rf_we=0 immediately, in_ready=1; after release, no stale writes appear.
